// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - requester/arbiter bundle for the shared 4:1 select bus
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 20
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output req, in0, in1, in2, in3,
        input  grant, sel, out, out_valid, busy
    );

    modport slave (
        input  req, in0, in1, in2, in3,
        output grant, sel, out, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the registered 4:1 select datapath
module mux4_rr_arbiter #(
    parameter int WIDTH     = 20,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       sel_q, sel_n;
    logic [7:0]       cnt, cnt_n;
    logic [3:0]       grant_q, grant_n;
    logic [WIDTH-1:0] out_q, out_n, sel_word;
    logic             out_valid_q;
    logic             beat, rel, found;
    logic [1:0]       scan_base, win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            sel_q       <= 2'd0;
            cnt         <= 8'd0;
            grant_q     <= 4'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            sel_q       <= sel_n;
            cnt         <= cnt_n;
            grant_q     <= grant_n;
            out_q       <= out_n;
            out_valid_q <= beat;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    sel_word = bus.in0;
            2'd1:    sel_word = bus.in1;
            2'd2:    sel_word = bus.in2;
            default: sel_word = bus.in3;
        endcase
    end

    // A release always re-arbitrates from owner+1, so the old owner is scanned last.
    always_comb begin
        beat      = (state == BUSY) && bus.req[sel_q];
        rel       = (state == BUSY) && (!bus.req[sel_q] || cnt == LAST_BEAT);
        scan_base = rel ? sel_q + 2'd1 : ptr;
    end

    // Scan downward so the lowest offset from scan_base is the last (winning) write.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = scan_base;
        for (int i = 3; i >= 0; i--) begin
            idx = scan_base + 2'(i);
            if (bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        cnt_n   = cnt;
        grant_n = grant_q;
        out_n   = beat ? sel_word : out_q;
        if (state == IDLE || rel) begin
            if (rel) begin
                ptr_n = sel_q + 2'd1;
            end
            cnt_n = 8'd0;
            if (found) begin
                state_n = BUSY;
                sel_n   = win;
                grant_n = 4'b0001 << win;
            end else begin
                state_n = IDLE;
                grant_n = 4'd0;
            end
        end else if (beat) begin
            cnt_n = cnt + 8'd1;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == BUSY);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux4_rr_arbiter_if #(.WIDTH(20)) bus_a ();
    mux4_rr_arbiter_if #(.WIDTH(20)) bus_b ();

    mux4_rr_arbiter #(.WIDTH(20), .MAX_BURST(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    mux4_rr_arbiter #(.WIDTH(20), .MAX_BURST(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus_a.req = 4'd0;
        bus_b.req = 4'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_a.grant !== 4'd0 || bus_a.sel !== 2'd0 || bus_a.out !== 20'd0 ||
            bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: grant=%b sel=%b out=%h valid=%b busy=%b, required all zero",
                     bus_a.grant, bus_a.sel, bus_a.out, bus_a.out_valid, bus_a.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus_a.in1 = 20'h12345;
        bus_a.req = 4'b0010;
        step();
        checks++;
        if (bus_a.grant !== 4'b0010 || bus_a.sel !== 2'd1 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b sel=%b busy=%b, required 0010 01 1",
                     bus_a.grant, bus_a.sel, bus_a.busy);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out !== 20'h12345) begin
                errors++;
                $display("FAIL single_beat%0d: valid=%b out=%h, required 1 12345",
                         k, bus_a.out_valid, bus_a.out);
            end
        end
        bus_a.req = 4'b0000;
        step();
        checks++;
        if (bus_a.grant !== 4'd0 || bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0 ||
            bus_a.sel !== 2'd1) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b valid=%b sel=%b, required 0000 0 0 01",
                     bus_a.grant, bus_a.busy, bus_a.out_valid, bus_a.sel);
        end
        // pointer is now 2: requester 3 must beat requester 0
        bus_a.req = 4'b1001;
        step();
        checks++;
        if (bus_a.grant !== 4'b1000) begin
            errors++;
            $display("FAIL single_ptr: grant=%b, required 1000", bus_a.grant);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_g;
        logic [19:0] exp_o;
        do_reset();
        bus_a.in0 = 20'h00000;
        bus_a.in1 = 20'h00001;
        bus_a.in2 = 20'h00002;
        bus_a.in3 = 20'h00003;
        bus_a.req = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            step();
            exp_g = 4'b0001 << ((k / 4) % 4);
            checks++;
            if (bus_a.grant !== exp_g) begin
                errors++;
                $display("FAIL rotation_grant k=%0d: grant=%b, required %b", k, bus_a.grant, exp_g);
            end
            if (k >= 1) begin
                exp_o = 20'(((k - 1) / 4) % 4);
                checks++;
                if (bus_a.out_valid !== 1'b1 || bus_a.out !== exp_o) begin
                    errors++;
                    $display("FAIL rotation_out k=%0d: valid=%b out=%h, required 1 %h",
                             k, bus_a.out_valid, bus_a.out, exp_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_a.in0 = 20'hABCDE;
        bus_a.req = 4'b0001;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (bus_a.grant !== 4'b0001 || bus_a.out_valid !== 1'b1 || bus_a.out !== 20'hABCDE) begin
                errors++;
                $display("FAIL regrant k=%0d: grant=%b valid=%b out=%h, required 0001 1 abcde",
                         k, bus_a.grant, bus_a.out_valid, bus_a.out);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus_a.req = 4'b0100;
        step();
        checks++;
        if (bus_a.grant !== 4'b0100) begin
            errors++;
            $display("FAIL drop_first: grant=%b, required 0100", bus_a.grant);
        end
        bus_a.req = 4'b1101;
        step();
        step();
        checks++;
        if (bus_a.grant !== 4'b0100) begin
            errors++;
            $display("FAIL drop_hold: grant=%b, required 0100", bus_a.grant);
        end
        bus_a.req = 4'b1001;
        step();
        checks++;
        if (bus_a.grant !== 4'b1000 || bus_a.sel !== 2'd3) begin
            errors++;
            $display("FAIL drop_next: grant=%b sel=%b, required 1000 11", bus_a.grant, bus_a.sel);
        end
        bus_a.req = 4'b0001;
        step();
        checks++;
        if (bus_a.grant !== 4'b0001) begin
            errors++;
            $display("FAIL drop_wrap: grant=%b, required 0001", bus_a.grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_a.in1 = 20'h55555;
        bus_a.req = 4'b0010;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.grant !== 4'd0 || bus_a.sel !== 2'd0 || bus_a.out !== 20'd0 ||
            bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: grant=%b sel=%b out=%h valid=%b busy=%b, required all zero",
                     bus_a.grant, bus_a.sel, bus_a.out, bus_a.out_valid, bus_a.busy);
        end
        bus_a.req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_a.grant !== 4'b0010) begin
            errors++;
            $display("FAIL async_reset_regrant: grant=%b, required 0010", bus_a.grant);
        end
    endtask

    task automatic test_burst1();
        logic [3:0]  exp_g;
        logic [19:0] exp_o;
        do_reset();
        bus_b.in0 = 20'h0A0A0;
        bus_b.in2 = 20'h0C0C0;
        bus_b.req = 4'b0101;
        for (int k = 0; k <= 8; k++) begin
            step();
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            checks++;
            if (bus_b.grant !== exp_g) begin
                errors++;
                $display("FAIL burst1_grant k=%0d: grant=%b, required %b", k, bus_b.grant, exp_g);
            end
            if (k >= 1) begin
                exp_o = (k % 2 == 1) ? 20'h0A0A0 : 20'h0C0C0;
                checks++;
                if (bus_b.out_valid !== 1'b1 || bus_b.out !== exp_o) begin
                    errors++;
                    $display("FAIL burst1_out k=%0d: valid=%b out=%h, required 1 %h",
                             k, bus_b.out_valid, bus_b.out, exp_o);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus_a.req = 4'd0;
        bus_a.in0 = '0;
        bus_a.in1 = '0;
        bus_a.in2 = '0;
        bus_a.in3 = '0;
        bus_b.req = 4'd0;
        bus_b.in0 = '0;
        bus_b.in1 = '0;
        bus_b.in2 = '0;
        bus_b.in3 = '0;
        test_reset();
        test_single();
        test_rotation();
        test_back_to_back();
        test_drop();
        test_async_reset();
        test_burst1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
